hazard_ctrl_tn: RTL and testbench
=================================

Name: hazard_ctrl_tn

Overview:
- Parametrised successor to the 5-stage hazard unit: replaces per-opcode stall equations with a generic Tnew/Tuse model.
- Keeps an internal shadow pipeline (E/M/W destination + Tnew, E rs/rt, M rt) advanced in lock-step with the datapath.
- Adds a multi-cycle mult/div busy tracker.
- Sits beside the datapath; consumes D-stage decode fields only; drives stall/flush and all forwarding selects.

Parameters:
- REG_AW, 5, register address width
- TW, 2, Tnew/Tuse width; all-ones Tuse = operand unused
- MULT_CYCLES, 5, busy cycles for mult/multu after E-entry edge
- DIV_CYCLES, 10, busy cycles for div/divu after E-entry edge

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- rs_d  in  REG_AW  D-stage rs address
- rt_d  in  REG_AW  D-stage rt address
- rs_tuse_d  in  TW  cycles after D until rs needed (0 branch/jr, 1 ALU, 2 store data); all-ones = unused
- rt_tuse_d  in  TW  same for rt
- dst_d  in  REG_AW  D-stage write register; 0 = no write
- tnew_d  in  TW  cycles until result ready, valued as in E (ALU 1, load 2, jal/lui 0)
- mdu_start_d  in  1  D instruction starts mult/div
- mdu_div_d  in  1  start is a divide
- mdu_use_d  in  1  D instruction touches HI/LO (mfhi/mflo/mthi/mtlo/mult/div)
- stall_f  out  1  hold PC
- stall_d  out  1  hold F/D register
- flush_e  out  1  insert bubble into D/E register
- fwd_rs_d, fwd_rt_d  out  2  D-stage selects: 00 RF, 01 W, 10 M, 11 E
- fwd_rs_e, fwd_rt_e  out  2  E-stage selects: 00 pipe, 01 W, 10 M
- fwd_rt_m  out  1  M-stage store data from W
- mdu_busy  out  1  mult/div in flight

Behaviour:
- Reset (rst_n low, async): all shadow slots = {dst 0, tnew 0, rs 0, rt 0}; MDU counter 0; start_e 0. Outputs settle combinationally: stall/flush 0, all fwd 0, mdu_busy 0.
- Shadow advance on every rising clk:
  - E <= stall ? bubble : {dst_d, tnew_d, rs_d, rt_d}.
  - M <= {dst_e, sat_dec(tnew_e), rt_e}.
  - W <= {dst_m, sat_dec(tnew_m)}.
  - sat_dec(0) = 0. W Tnew is always 0.
- Stall terms (combinational):
  - Data stall for rs: rs_d!=0, rs_tuse_d!=all-ones, and ((rs_d==dst_e and tnew_e>rs_tuse_d) or (rs_d==dst_m and tnew_m>rs_tuse_d)).
  - Same rule for rt.
  - MDU stall: mdu_use_d and mdu_busy.
  - stall = any term. stall_f = stall_d = flush_e = stall.
- Forward select: youngest shadow stage whose dst equals the operand and is nonzero.
  - If that stage's tnew==0, select it; otherwise select 00.
  - Selecting 00 with a nonzero tnew only occurs while stall is high, or in E/M where the value is already guaranteed.
  - Older matches never override a younger match.
- fwd_rt_m = (rt_m!=0 and rt_m==dst_w).
- Register 0: never stalls, never forwards.
- MDU tracker:
  - start_e <= mdu_start_d and !stall.
  - When start_e is 1, cnt <= mdu_div_e ? DIV_CYCLES : MULT_CYCLES.
  - Otherwise cnt decrements while nonzero.
  - mdu_busy = start_e | (cnt!=0), i.e. busy for N+1 cycles from the E-entry edge.
  - A new start cannot arrive while busy: mdu_start_d implies mdu_use_d.
  - Counter width = clog2(max(MULT_CYCLES, DIV_CYCLES)+1).
- Simultaneous data and MDU stall: single bubble per cycle; no double-count.
- Reset mid-div: counter and start_e clear immediately; mdu_busy drops asynchronously.
- No internal latency on outputs: all are combinational from current inputs and shadow state.

Decomposition:
- Shared package hazard_pkg:
  - TUSE_NONE (all-ones)
  - fwd encodings FWD_RF/FWD_W/FWD_M/FWD_E
  - shadow-slot struct {dst, tnew, rs, rt}
  - sat_dec function
- One natural sub-module: mdu_busy_ctr (start, is_div, busy, counter).

Test Plan:
- lw $2 (tnew_d=2), then add $3,$2,$4 (rs_tuse 1) → 1 stall cycle; next cycle no stall; when add reaches E, fwd_rs_e=01.
- addu $5 (tnew 1), then beq $5,$0 (tuse 0) → 1 stall cycle; following cycle fwd_rs_d=10.
- jal (dst 31, tnew 0), then jr $31 → no stall; fwd_rs_d=11.
- div at D, then mflo → stall for DIV_CYCLES+1=11 cycles after div enters E; mflo enters E on cycle 12; mdu_busy falls same cycle the stall releases.
- lw $0 / addu $0 followed by consumers of $0 → stall=0 and all fwd=00 throughout.
- rst_n low for one cycle in the middle of a div busy window → mdu_busy and stall drop asynchronously; shadow slots read bubble after release.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the Tnew/Tuse hazard controller.
package hazard_pkg;

  localparam int SLOT_AW = 5;
  localparam int SLOT_TW = 2;

  // An all-ones Tuse marks an operand the instruction never reads.
  localparam logic [SLOT_TW-1:0] TUSE_NONE = '1;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;
  localparam logic [1:0] FWD_E  = 2'b11;

  typedef struct packed {
    logic [SLOT_AW-1:0] dst;
    logic [SLOT_TW-1:0] tnew;
    logic [SLOT_AW-1:0] rs;
    logic [SLOT_AW-1:0] rt;
  } slot_t;

  function automatic logic [SLOT_TW-1:0] sat_dec(input logic [SLOT_TW-1:0] t);
    return (t == '0) ? '0 : t - 1'b1;
  endfunction

endpackage

// File: rtl/mdu_busy_ctr.sv
// Tracks an in-flight mult/div: busy from the cycle it enters E until its
// cycle budget has drained.
module mdu_busy_ctr #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic isDiv,
  output logic busy
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);

  logic          startE;
  logic          divE;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      startE <= 1'b0;
      divE   <= 1'b0;
      cnt    <= '0;
    end else begin
      startE <= start;
      divE   <= isDiv;
      if (startE) begin
        cnt <= divE ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
      end else if (cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  // The E-entry cycle itself counts as busy, giving N+1 busy cycles.
  assign busy = startE | (cnt != '0);

endmodule

// File: rtl/hazard_ctrl_tn.sv
// Tnew/Tuse hazard unit: shadow E/M/W pipeline, stall generation and
// forwarding selects for a 5-stage datapath, plus mult/div busy tracking.
module hazard_ctrl_tn
  import hazard_pkg::*;
#(
  parameter int REG_AW      = 5,
  parameter int TW          = 2,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] rs_d,
  input  logic [REG_AW-1:0] rt_d,
  input  logic [TW-1:0]     rs_tuse_d,
  input  logic [TW-1:0]     rt_tuse_d,
  input  logic [REG_AW-1:0] dst_d,
  input  logic [TW-1:0]     tnew_d,
  input  logic              mdu_start_d,
  input  logic              mdu_div_d,
  input  logic              mdu_use_d,
  output logic              stall_f,
  output logic              stall_d,
  output logic              flush_e,
  output logic [1:0]        fwd_rs_d,
  output logic [1:0]        fwd_rt_d,
  output logic [1:0]        fwd_rs_e,
  output logic [1:0]        fwd_rt_e,
  output logic              fwd_rt_m,
  output logic              mdu_busy
);

  slot_t             slotE;
  logic [REG_AW-1:0] mDst;
  logic [TW-1:0]     mTnew;
  logic [REG_AW-1:0] mRt;
  logic [REG_AW-1:0] wDst;
  logic [TW-1:0]     wTnew;

  logic                   stall;
  logic                   mduBusy;
  logic [1:0]             dataHaz;
  logic [1:0][REG_AW-1:0] opD;
  logic [1:0][TW-1:0]     opTuse;
  logic [1:0][REG_AW-1:0] opE;
  logic [1:0][1:0]        fwdD;
  logic [1:0][1:0]        fwdE;

  // Index 0 is the rs operand, index 1 the rt operand.
  assign opD    = {rt_d, rs_d};
  assign opTuse = {rt_tuse_d, rs_tuse_d};
  assign opE    = {slotE.rt, slotE.rs};

  for (genvar gi = 0; gi < 2; gi++) begin : g_op
    assign dataHaz[gi] = (opD[gi] != '0) && (opTuse[gi] != TUSE_NONE) &&
                         (((opD[gi] == slotE.dst) && (slotE.tnew > opTuse[gi])) ||
                          ((opD[gi] == mDst) && (mTnew > opTuse[gi])));

    // Youngest match wins; a match whose value is not ready yet selects RF.
    assign fwdD[gi] = (opD[gi] == '0)       ? FWD_RF :
                      (opD[gi] == slotE.dst) ? ((slotE.tnew == '0) ? FWD_E : FWD_RF) :
                      (opD[gi] == mDst)      ? ((mTnew == '0) ? FWD_M : FWD_RF) :
                      (opD[gi] == wDst)      ? ((wTnew == '0) ? FWD_W : FWD_RF) :
                                               FWD_RF;

    assign fwdE[gi] = (opE[gi] == '0)  ? FWD_RF :
                      (opE[gi] == mDst) ? ((mTnew == '0) ? FWD_M : FWD_RF) :
                      (opE[gi] == wDst) ? ((wTnew == '0) ? FWD_W : FWD_RF) :
                                          FWD_RF;
  end

  // Data and MDU hazards merge into one bubble; they never stack.
  assign stall = (|dataHaz) | (mdu_use_d & mduBusy);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slotE <= '0;
      mDst  <= '0;
      mTnew <= '0;
      mRt   <= '0;
      wDst  <= '0;
      wTnew <= '0;
    end else begin
      slotE <= stall ? slot_t'('0) : slot_t'{dst: dst_d, tnew: tnew_d, rs: rs_d, rt: rt_d};
      mDst  <= slotE.dst;
      mTnew <= sat_dec(slotE.tnew);
      mRt   <= slotE.rt;
      wDst  <= mDst;
      wTnew <= sat_dec(mTnew);
    end
  end

  mdu_busy_ctr #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_mdu (
    .clk  (clk),
    .rst_n(rst_n),
    .start(mdu_start_d & ~stall),
    .isDiv(mdu_div_d),
    .busy (mduBusy)
  );

  assign stall_f  = stall;
  assign stall_d  = stall;
  assign flush_e  = stall;
  assign fwd_rs_d = fwdD[0];
  assign fwd_rt_d = fwdD[1];
  assign fwd_rs_e = fwdE[0];
  assign fwd_rt_e = fwdE[1];
  assign fwd_rt_m = (mRt != '0) && (mRt == wDst);
  assign mdu_busy = mduBusy;

endmodule

// File: tb/tb_hazard_ctrl_tn.sv
// Table-driven bench for hazard_ctrl_tn with a scoreboard of expected outputs.
module tb_hazard_ctrl_tn;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;
  localparam int NVEC   = 23;

  logic       clk;
  logic       rst_n;
  logic [4:0] rs_d, rt_d, dst_d;
  logic [1:0] rs_tuse_d, rt_tuse_d, tnew_d;
  logic       mdu_start_d, mdu_div_d, mdu_use_d;
  logic       stall_f, stall_d, flush_e, fwd_rt_m, mdu_busy;
  logic [1:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;

  typedef struct packed {
    logic [4:0] rs;
    logic [1:0] rsT;
    logic [4:0] rt;
    logic [1:0] rtT;
    logic [4:0] dst;
    logic [1:0] tnew;
    logic       mStart;
    logic       mDiv;
    logic       mUse;
  } stim_t;

  typedef struct packed {
    logic       stall;
    logic [1:0] fRsD;
    logic [1:0] fRtD;
    logic [1:0] fRsE;
    logic [1:0] fRtE;
    logic       fRtM;
    logic       busy;
  } exp_t;

  typedef struct packed {
    stim_t s;
    exp_t  e;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[NVEC];
  int   passed = 0;
  int   total  = 0;

  hazard_ctrl_tn #(
    .REG_AW(5), .TW(2), .MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .rs_d(rs_d), .rt_d(rt_d), .rs_tuse_d(rs_tuse_d), .rt_tuse_d(rt_tuse_d),
    .dst_d(dst_d), .tnew_d(tnew_d),
    .mdu_start_d(mdu_start_d), .mdu_div_d(mdu_div_d), .mdu_use_d(mdu_use_d),
    .stall_f(stall_f), .stall_d(stall_d), .flush_e(flush_e),
    .fwd_rs_d(fwd_rs_d), .fwd_rt_d(fwd_rt_d),
    .fwd_rs_e(fwd_rs_e), .fwd_rt_e(fwd_rt_e),
    .fwd_rt_m(fwd_rt_m), .mdu_busy(mdu_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input int rs, input int rsT, input int rt, input int rtT,
                              input int dst, input int tnew, input int st,
                              input int frsd, input int frtd, input int frse,
                              input int frte, input int frtm);
    vec_t v;
    v.s.rs = 5'(rs);  v.s.rsT = 2'(rsT);  v.s.rt = 5'(rt);  v.s.rtT = 2'(rtT);
    v.s.dst = 5'(dst); v.s.tnew = 2'(tnew);
    v.s.mStart = 1'b0; v.s.mDiv = 1'b0; v.s.mUse = 1'b0;
    v.e.stall = 1'(st); v.e.fRsD = 2'(frsd); v.e.fRtD = 2'(frtd);
    v.e.fRsE = 2'(frse); v.e.fRtE = 2'(frte); v.e.fRtM = 1'(frtm); v.e.busy = 1'b0;
    return v;
  endfunction

  function automatic exp_t ex(input int st, input int frsd, input int frse, input int busy);
    exp_t e;
    e = '0;
    e.stall = 1'(st); e.fRsD = 2'(frsd); e.fRsE = 2'(frse); e.busy = 1'(busy);
    return e;
  endfunction

  task automatic drive(input stim_t s);
    rs_d = s.rs; rs_tuse_d = s.rsT; rt_d = s.rt; rt_tuse_d = s.rtT;
    dst_d = s.dst; tnew_d = s.tnew;
    mdu_start_d = s.mStart; mdu_div_d = s.mDiv; mdu_use_d = s.mUse;
  endtask

  task automatic checkField(input string name, input logic [1:0] act, input logic [1:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    else passed++;
  endtask

  task automatic compareNow(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      $display("FAIL %s.scoreboard: got empty queue, expected an entry", tag);
    end else begin
      e = sb.pop_front();
      checkField({tag, ".stall_f"},  {1'b0, stall_f},  {1'b0, e.stall});
      checkField({tag, ".stall_d"},  {1'b0, stall_d},  {1'b0, e.stall});
      checkField({tag, ".flush_e"},  {1'b0, flush_e},  {1'b0, e.stall});
      checkField({tag, ".fwd_rs_d"}, fwd_rs_d,         e.fRsD);
      checkField({tag, ".fwd_rt_d"}, fwd_rt_d,         e.fRtD);
      checkField({tag, ".fwd_rs_e"}, fwd_rs_e,         e.fRsE);
      checkField({tag, ".fwd_rt_e"}, fwd_rt_e,         e.fRtE);
      checkField({tag, ".fwd_rt_m"}, {1'b0, fwd_rt_m}, {1'b0, e.fRtM});
      checkField({tag, ".mdu_busy"}, {1'b0, mdu_busy}, {1'b0, e.busy});
    end
  endtask

  // Drive one D-stage instruction for one cycle, checking mid-cycle.
  task automatic apply(input stim_t s, input exp_t e, input string tag);
    drive(s);
    sb.push_back(e);
    @(negedge clk);
    compareNow(tag);
    @(posedge clk);
    #1;
  endtask

  // mult/div followed by mflo, then consumers of mflo's result.
  task automatic mduRun(input logic isDiv, input int n, input string tag);
    stim_t sDiv, sMflo, sUse, sNop;
    sDiv  = mk(10, 1, 11, 1, 0, 0, 0, 0, 0, 0, 0, 0).s;
    sDiv.mStart = 1'b1; sDiv.mDiv = isDiv; sDiv.mUse = 1'b1;
    sMflo = mk(0, 3, 0, 3, 12, 1, 0, 0, 0, 0, 0, 0).s;
    sMflo.mUse = 1'b1;
    sUse  = mk(12, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0).s;
    sNop  = mk(0, 3, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0).s;
    apply(sDiv, ex(0, 0, 0, 0), {tag, ".start"});
    for (int c = 0; c <= n; c++) apply(sMflo, ex(1, 0, 0, 1), $sformatf("%s.busy%0d", tag, c));
    apply(sMflo, ex(0, 0, 0, 0), {tag, ".release"});
    apply(sUse,  ex(1, 0, 0, 0), {tag, ".mfloInE"});
    apply(sUse,  ex(0, 2, 0, 0), {tag, ".fwdM"});
    apply(sNop,  ex(0, 0, 1, 0), {tag, ".fwdEW"});
    apply(sNop,  ex(0, 0, 0, 0), {tag, ".drain"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t sDiv, sLw, sCons, sNop;
    //               rs rsT rt rtT dst tn | st rsD rtD rsE rtE rtM
    vecs[0]  = mk( 1, 1,  0, 3,  2, 2,   0, 0, 0, 0, 0, 0);
    vecs[1]  = mk( 2, 1,  4, 1,  3, 1,   1, 0, 0, 0, 0, 0);
    vecs[2]  = mk( 2, 1,  4, 1,  3, 1,   0, 0, 0, 0, 0, 0);
    vecs[3]  = mk( 0, 3,  0, 3,  0, 0,   0, 0, 0, 1, 0, 0);
    vecs[4]  = mk( 6, 1,  7, 1,  5, 1,   0, 0, 0, 0, 0, 0);
    vecs[5]  = mk( 5, 0,  0, 0,  0, 0,   1, 0, 0, 0, 0, 0);
    vecs[6]  = mk( 5, 0,  0, 0,  0, 0,   0, 2, 0, 0, 0, 0);
    vecs[7]  = mk( 0, 3,  0, 3, 31, 0,   0, 0, 0, 1, 0, 0);
    vecs[8]  = mk(31, 0,  0, 3,  0, 0,   0, 3, 0, 0, 0, 0);
    vecs[9]  = mk( 0, 3,  0, 3,  0, 0,   0, 0, 0, 2, 0, 0);
    vecs[10] = mk( 1, 1,  0, 3,  0, 2,   0, 0, 0, 0, 0, 0);
    vecs[11] = mk( 0, 0,  0, 0,  0, 1,   0, 0, 0, 0, 0, 0);
    vecs[12] = mk( 0, 0,  0, 0,  0, 0,   0, 0, 0, 0, 0, 0);
    vecs[13] = mk( 0, 1,  0, 3,  8, 2,   0, 0, 0, 0, 0, 0);
    vecs[14] = mk( 0, 1,  0, 1,  8, 1,   0, 0, 0, 0, 0, 0);
    vecs[15] = mk( 0, 1,  8, 2,  0, 0,   0, 0, 0, 0, 0, 0);
    vecs[16] = mk( 0, 3,  0, 3,  0, 0,   0, 0, 0, 0, 2, 0);
    vecs[17] = mk( 8, 1,  0, 3,  0, 0,   0, 1, 0, 0, 0, 1);
    vecs[18] = mk( 0, 1,  0, 3,  9, 2,   0, 0, 0, 0, 0, 0);
    vecs[19] = mk( 0, 1,  9, 2,  0, 0,   0, 0, 0, 0, 0, 0);
    vecs[20] = mk( 0, 0,  9, 0,  0, 0,   1, 0, 0, 0, 0, 0);
    vecs[21] = mk( 0, 0,  9, 0,  0, 0,   0, 0, 1, 0, 0, 1);
    vecs[22] = mk( 0, 3,  0, 3,  0, 0,   0, 0, 0, 0, 0, 0);

    sNop = vecs[22].s;
    rst_n = 1'b0;
    drive(sNop);
    sb.push_back('0);
    #3;
    compareNow("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) apply(vecs[i].s, vecs[i].e, $sformatf("vec%0d", i));

    mduRun(1'b1, DIV_N, "div");
    mduRun(1'b0, MULT_N, "mult");

    // Reset in the middle of a divide, with lw $13 sitting in E.
    sDiv = mk(10, 1, 11, 1, 0, 0, 0, 0, 0, 0, 0, 0).s;
    sDiv.mStart = 1'b1; sDiv.mDiv = 1'b1; sDiv.mUse = 1'b1;
    sLw  = mk(0, 1, 0, 3, 13, 2, 0, 0, 0, 0, 0, 0).s;
    sCons = mk(13, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0).s;
    sCons.mUse = 1'b1;
    apply(sDiv, ex(0, 0, 0, 0), "rst.div");
    apply(sLw,  ex(0, 0, 0, 1), "rst.lw");
    drive(sCons);
    sb.push_back(ex(1, 0, 0, 1));
    @(negedge clk);
    compareNow("rst.pre");
    #2;
    rst_n = 1'b0;
    #1;
    sb.push_back(ex(0, 0, 0, 0));
    compareNow("rst.async");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    sb.push_back(ex(0, 0, 0, 0));
    compareNow("rst.release");
    @(posedge clk);
    #1;
    apply(sNop, ex(0, 0, 0, 0), "rst.after");
    apply(sNop, ex(0, 0, 0, 0), "rst.idle");

    if (sb.size() != 0) begin
      total++;
      $display("FAIL scoreboard.leftover: got %0d entries, expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
